inst_axi_rd_bridge: RTL and testbench

- Upstream neighbour of the fetch stage. Slave side is the instruction sram-like interface (req / addr_ok / data_ok); master side is an AXI4 read-address (AR) and read-data (R) channel.
- Converts each fetch request into a single-beat AXI read.
- Keeps up to DEPTH requests outstanding and returns data strictly in request order.
- Never issues AXI writes.

---
 rtl/inst_axi_rd_bridge.sv | 108 ++++++++++
 tb/tb_inst_axi_rd_bridge.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_axi_rd_bridge.sv
// Instruction fetch bridge: sram-like request/response to single-beat AXI4 reads, in order.
// Latency: addr_ok same cycle as req; data_ok one cycle after the R beat. AR stall holds addr_ok low.
module inst_axi_rd_bridge #(
    parameter int         DEPTH  = 2,
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);
    typedef enum logic {AR_IDLE, AR_BUSY} ar_state_t;

    localparam logic [1:0] DEPTH_C = 2'(DEPTH);

    ar_state_t  state;
    logic [1:0] cnt;
    logic [1:0] size_q;
    logic       cnt_inc;
    logic       cnt_dec;

    wire unused_r = ^{rid, rresp, rlast};

    assign arid    = AXI_ID;
    assign arlen   = 8'd0;
    assign arburst = 2'b01;
    assign arsize  = {1'b0, size_q};
    assign rready  = (cnt != 2'd0);

    // The entry retiring via data_ok this cycle frees its slot for a same-cycle accept.
    assign inst_sram_addr_ok = (state == AR_IDLE) && inst_sram_req && !inst_sram_wr &&
                               ((cnt < DEPTH_C) || inst_sram_data_ok);

    assign cnt_inc = inst_sram_addr_ok;
    assign cnt_dec = inst_sram_data_ok && (cnt != 2'd0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= AR_IDLE;
            arvalid <= 1'b0;
            araddr  <= 32'd0;
            size_q  <= 2'd0;
        end else begin
            case (state)
                AR_IDLE: begin
                    if (inst_sram_addr_ok) begin
                        araddr  <= inst_sram_addr;
                        size_q  <= inst_sram_size;
                        arvalid <= 1'b1;
                        state   <= AR_BUSY;
                    end
                end
                AR_BUSY: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        state   <= AR_IDLE;
                    end
                end
                default: begin
                    arvalid <= 1'b0;
                    state   <= AR_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= 2'd0;
        end else begin
            case ({cnt_inc, cnt_dec})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inst_sram_data_ok <= 1'b0;
            inst_sram_rdata   <= 32'd0;
        end else begin
            inst_sram_data_ok <= rvalid && rready;
            if (rvalid && rready) begin
                inst_sram_rdata <= rdata;
            end
        end
    end
endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Directed scenarios plus a randomized run against an in-order transaction model.
module tb_inst_axi_rd_bridge;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req = 1'b0, wr = 1'b0;
    logic [1:0]  size = 2'd2;
    logic [31:0] addr = 32'd0;
    logic        addr_ok, data_ok;
    logic [31:0] sram_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [3:0]  rid = 4'd0;
    logic [31:0] rdata = 32'd0;
    logic [1:0]  rresp = 2'd0;
    logic        rlast = 1'b1;
    logic        rvalid = 1'b0;
    logic        rready;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    inst_axi_rd_bridge #(.DEPTH(DEPTH), .AXI_ID(4'd0)) dut (
        .clk(clk), .resetn(resetn),
        .inst_sram_req(req), .inst_sram_wr(wr), .inst_sram_size(size), .inst_sram_addr(addr),
        .inst_sram_addr_ok(addr_ok), .inst_sram_data_ok(data_ok), .inst_sram_rdata(sram_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    function automatic logic [31:0] fdat(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5a5a_0f0f;
    endfunction

    task automatic idle_inputs;
        req = 1'b0; wr = 1'b0; size = 2'd2; addr = 32'd0;
        arready = 1'b0; rvalid = 1'b0; rdata = 32'd0;
    endtask

    // All tasks start and end just after a rising edge.
    task automatic next_cycle;
        @(posedge clk); #1;
    endtask

    task automatic do_reset;
        idle_inputs();
        resetn = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        resetn = 1'b1;
    endtask

    task automatic test_reset;
        idle_inputs();
        resetn = 1'b0;
        #2;
        checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid: got %b want 0", arvalid); end
        checks++; if (araddr !== 32'd0) begin errors++; $display("FAIL reset_araddr: got %h want 0", araddr); end
        checks++; if (arsize !== 3'd0) begin errors++; $display("FAIL reset_arsize: got %h want 0", arsize); end
        checks++; if (data_ok !== 1'b0) begin errors++; $display("FAIL reset_data_ok: got %b want 0", data_ok); end
        checks++; if (sram_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h want 0", sram_rdata); end
        checks++; if (rready !== 1'b0) begin errors++; $display("FAIL reset_rready: got %b want 0", rready); end
        checks++; if ({arid, arlen, arburst} !== {4'd0, 8'd0, 2'b01}) begin errors++; $display("FAIL reset_constants: got %h want %h", {arid, arlen, arburst}, {4'd0, 8'd0, 2'b01}); end
        @(posedge clk); #1;
        resetn = 1'b1;
    endtask

    task automatic test_single_fetch;
        req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h1c00_0000; arready = 1'b1;
        @(negedge clk);
        checks++; if (addr_ok !== 1'b1) begin errors++; $display("FAIL single_addr_ok: got %b want 1", addr_ok); end
        checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL single_arvalid_c0: got %b want 0", arvalid); end
        next_cycle(); req = 1'b0;
        @(negedge clk);
        checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL single_arvalid_c1: got %b want 1", arvalid); end
        checks++; if (araddr !== 32'h1c00_0000) begin errors++; $display("FAIL single_araddr: got %h want 1c000000", araddr); end
        checks++; if (arsize !== 3'b010) begin errors++; $display("FAIL single_arsize: got %b want 010", arsize); end
        next_cycle(); arready = 1'b0; rvalid = 1'b1; rdata = 32'h0280_0000;
        @(negedge clk);
        checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL single_arvalid_c2: got %b want 0", arvalid); end
        checks++; if (rready !== 1'b1) begin errors++; $display("FAIL single_rready: got %b want 1", rready); end
        checks++; if (data_ok !== 1'b0) begin errors++; $display("FAIL single_data_ok_c2: got %b want 0", data_ok); end
        next_cycle(); rvalid = 1'b0; rdata = 32'hdead_beef;
        @(negedge clk);
        checks++; if (data_ok !== 1'b1) begin errors++; $display("FAIL single_data_ok_c3: got %b want 1", data_ok); end
        checks++; if (sram_rdata !== 32'h0280_0000) begin errors++; $display("FAIL single_rdata: got %h want 02800000", sram_rdata); end
        next_cycle();
        @(negedge clk);
        checks++; if (data_ok !== 1'b0) begin errors++; $display("FAIL single_data_ok_c4: got %b want 0", data_ok); end
        checks++; if (rready !== 1'b0) begin errors++; $display("FAIL single_cnt_zero: rready got %b want 0", rready); end
        checks++; if (sram_rdata !== 32'h0280_0000) begin errors++; $display("FAIL single_rdata_hold: got %h want 02800000", sram_rdata); end
        next_cycle();
    endtask

    task automatic test_ar_backpressure;
        int hs = 0;
        do_reset();
        req = 1'b1; addr = 32'h1c00_0040; arready = 1'b0;
        @(negedge clk);
        checks++; if (addr_ok !== 1'b1) begin errors++; $display("FAIL bp_accept: got %b want 1", addr_ok); end
        next_cycle(); addr = 32'h1c00_0080;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (arvalid && arready) hs++;
            checks++; if (arvalid !== 1'b1 || araddr !== 32'h1c00_0040) begin errors++; $display("FAIL bp_stable[%0d]: arvalid=%b araddr=%h want 1 1c000040", i, arvalid, araddr); end
            checks++; if (addr_ok !== 1'b0) begin errors++; $display("FAIL bp_addr_ok[%0d]: got %b want 0", i, addr_ok); end
            next_cycle();
        end
        req = 1'b0; arready = 1'b1;
        @(negedge clk);
        if (arvalid && arready) hs++;
        next_cycle();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (arvalid && arready) hs++;
            next_cycle();
        end
        checks++; if (hs !== 1) begin errors++; $display("FAIL bp_handshakes: got %0d want 1", hs); end
        arready = 1'b0; rvalid = 1'b1; rdata = fdat(32'h1c00_0040);
        next_cycle(); rvalid = 1'b0;
        @(negedge clk);
        checks++; if (data_ok !== 1'b1 || sram_rdata !== fdat(32'h1c00_0040)) begin errors++; $display("FAIL bp_data: data_ok=%b rdata=%h want 1 %h", data_ok, sram_rdata, fdat(32'h1c00_0040)); end
        next_cycle();
    endtask

    // Accepts two fetches (each AR handshaked immediately); ends with both outstanding.
    task automatic issue_two(input logic [31:0] a0, input logic [31:0] a1, input string tag);
        req = 1'b1; addr = a0; arready = 1'b1;
        @(negedge clk);
        checks++; if (addr_ok !== 1'b1) begin errors++; $display("FAIL %s_accept0: got %b want 1", tag, addr_ok); end
        next_cycle(); req = 1'b0;
        next_cycle(); req = 1'b1; addr = a1;
        @(negedge clk);
        checks++; if (addr_ok !== 1'b1) begin errors++; $display("FAIL %s_accept1: got %b want 1", tag, addr_ok); end
        next_cycle(); req = 1'b0;
    endtask

    task automatic test_full;
        do_reset();
        issue_two(32'h1c00_0000, 32'h1c00_0004, "full");
        req = 1'b1; addr = 32'h1c00_0008;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (addr_ok !== 1'b0) begin errors++; $display("FAIL full_blocked[%0d]: got %b want 0", i, addr_ok); end
            next_cycle();
        end
        rvalid = 1'b1; rdata = fdat(32'h1c00_0000);
        @(negedge clk);
        checks++; if (addr_ok !== 1'b0) begin errors++; $display("FAIL full_blocked_rbeat: got %b want 0", addr_ok); end
        next_cycle(); rvalid = 1'b0;
        @(negedge clk);
        checks++; if (data_ok !== 1'b1 || sram_rdata !== fdat(32'h1c00_0000)) begin errors++; $display("FAIL full_data0: data_ok=%b rdata=%h want 1 %h", data_ok, sram_rdata, fdat(32'h1c00_0000)); end
        checks++; if (addr_ok !== 1'b1) begin errors++; $display("FAIL full_accept_on_data_ok: got %b want 1", addr_ok); end
        next_cycle(); req = 1'b0;
        @(negedge clk);
        checks++; if (arvalid !== 1'b1 || araddr !== 32'h1c00_0008) begin errors++; $display("FAIL full_ar2: arvalid=%b araddr=%h want 1 1c000008", arvalid, araddr); end
        next_cycle(); req = 1'b1; addr = 32'h1c00_000c;
        @(negedge clk);
        checks++; if (addr_ok !== 1'b0) begin errors++; $display("FAIL full_cnt_stays_2: addr_ok got %b want 0", addr_ok); end
        next_cycle(); req = 1'b0; rvalid = 1'b1; rdata = fdat(32'h1c00_0004);
        next_cycle(); rdata = fdat(32'h1c00_0008);
        @(negedge clk);
        checks++; if (data_ok !== 1'b1 || sram_rdata !== fdat(32'h1c00_0004)) begin errors++; $display("FAIL full_data1: data_ok=%b rdata=%h want 1 %h", data_ok, sram_rdata, fdat(32'h1c00_0004)); end
        next_cycle(); rvalid = 1'b0;
        @(negedge clk);
        checks++; if (data_ok !== 1'b1 || sram_rdata !== fdat(32'h1c00_0008)) begin errors++; $display("FAIL full_data2: data_ok=%b rdata=%h want 1 %h", data_ok, sram_rdata, fdat(32'h1c00_0008)); end
        next_cycle();
        @(negedge clk);
        checks++; if (data_ok !== 1'b0 || rready !== 1'b0) begin errors++; $display("FAIL full_drained: data_ok=%b rready=%b want 0 0", data_ok, rready); end
        next_cycle();
    endtask

    task automatic test_back_to_back;
        do_reset();
        issue_two(32'h1c00_0100, 32'h1c00_0104, "b2b");
        arready = 1'b0; rvalid = 1'b1; rdata = 32'h1111_1111;
        next_cycle(); rdata = 32'h2222_2222;
        @(negedge clk);
        checks++; if (data_ok !== 1'b1 || sram_rdata !== 32'h1111_1111) begin errors++; $display("FAIL b2b_first: data_ok=%b rdata=%h want 1 11111111", data_ok, sram_rdata); end
        next_cycle(); rvalid = 1'b0; rdata = 32'h3333_3333;
        @(negedge clk);
        checks++; if (data_ok !== 1'b1 || sram_rdata !== 32'h2222_2222) begin errors++; $display("FAIL b2b_second: data_ok=%b rdata=%h want 1 22222222", data_ok, sram_rdata); end
        next_cycle();
        @(negedge clk);
        checks++; if (data_ok !== 1'b0 || sram_rdata !== 32'h2222_2222) begin errors++; $display("FAIL b2b_after: data_ok=%b rdata=%h want 0 22222222", data_ok, sram_rdata); end
        next_cycle();
    endtask

    task automatic test_write_reject;
        do_reset();
        req = 1'b1; wr = 1'b1; addr = 32'h1c00_0200; arready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (addr_ok !== 1'b0 || arvalid !== 1'b0) begin errors++; $display("FAIL wr_reject[%0d]: addr_ok=%b arvalid=%b want 0 0", i, addr_ok, arvalid); end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_async_reset;
        do_reset();
        req = 1'b1; addr = 32'h1c00_0300; arready = 1'b1;
        next_cycle(); req = 1'b0;
        next_cycle(); req = 1'b1; addr = 32'h1c00_0304; arready = 1'b0;
        rvalid = 1'b1; rdata = 32'hcafe_f00d;
        next_cycle(); req = 1'b0; rvalid = 1'b0;
        @(negedge clk);
        checks++; if (arvalid !== 1'b1 || data_ok !== 1'b1 || rready !== 1'b1) begin errors++; $display("FAIL arst_setup: arvalid=%b data_ok=%b rready=%b want 1 1 1", arvalid, data_ok, rready); end
        #2 resetn = 1'b0;
        #1;
        checks++; if (arvalid !== 1'b0 || data_ok !== 1'b0) begin errors++; $display("FAIL arst_immediate: arvalid=%b data_ok=%b want 0 0", arvalid, data_ok); end
        checks++; if (rready !== 1'b0 || sram_rdata !== 32'd0) begin errors++; $display("FAIL arst_cnt_rdata: rready=%b rdata=%h want 0 0", rready, sram_rdata); end
        @(posedge clk); #1;
        resetn = 1'b1;
        test_single_fetch();
    endtask

    // Randomized traffic against a transaction-level model: FIFO of accepted addresses,
    // one AR in flight at a time, slave returns data in AR order.
    task automatic test_random;
        logic [31:0] order_q[$];
        logic [31:0] ar_q[$];
        logic [31:0] slave_q[$];
        logic [31:0] last_rdata = 32'd0;
        logic        beat_pend = 1'b0;
        int          outstanding = 0;
        logic        e_addr_ok, e_arvalid, e_rready;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            req = ($urandom_range(0, 2) != 0);
            wr = ($urandom_range(0, 7) == 0);
            addr = $urandom() & 32'hffff_fffc;
            arready = $urandom_range(0, 1);
            rvalid = (slave_q.size() != 0) && ($urandom_range(0, 1) == 1);
            rdata = rvalid ? fdat(slave_q[0]) : $urandom();
            @(negedge clk);
            e_arvalid = (ar_q.size() != 0);
            e_rready = (outstanding != 0);
            e_addr_ok = req && !wr && !e_arvalid && ((outstanding - int'(beat_pend)) < DEPTH);
            checks++; if (addr_ok !== e_addr_ok) begin errors++; $display("FAIL rnd_addr_ok@%0d: got %b want %b", cyc, addr_ok, e_addr_ok); end
            checks++; if (arvalid !== e_arvalid) begin errors++; $display("FAIL rnd_arvalid@%0d: got %b want %b", cyc, arvalid, e_arvalid); end
            if (e_arvalid) begin
                checks++; if (araddr !== ar_q[0]) begin errors++; $display("FAIL rnd_araddr@%0d: got %h want %h", cyc, araddr, ar_q[0]); end
            end
            checks++; if (rready !== e_rready) begin errors++; $display("FAIL rnd_rready@%0d: got %b want %b", cyc, rready, e_rready); end
            checks++; if (data_ok !== beat_pend) begin errors++; $display("FAIL rnd_data_ok@%0d: got %b want %b", cyc, data_ok, beat_pend); end
            if (beat_pend) begin
                last_rdata = fdat(order_q.pop_front());
                outstanding--;
            end
            checks++; if (sram_rdata !== last_rdata) begin errors++; $display("FAIL rnd_rdata@%0d: got %h want %h", cyc, sram_rdata, last_rdata); end
            beat_pend = rvalid && e_rready;
            if (beat_pend) void'(slave_q.pop_front());
            if (e_arvalid && arready) slave_q.push_back(ar_q.pop_front());
            if (e_addr_ok) begin
                ar_q.push_back(addr);
                order_q.push_back(addr);
                outstanding++;
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_fetch();
        test_ar_backpressure();
        test_full();
        test_back_to_back();
        test_write_reject();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
